// File: rtl/aludec_mdu_pkg.sv
// Shared definitions for the EX-stage ALU decoder and multiply/divide unit:
// ALU control codes, alu_op codes, funct constants, FSM state encoding and
// small decode helpers.
package aludec_mdu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_NOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_LUI  = 4'b1011;
   localparam logic [3:0] ALU_ILL  = 4'b1111;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_OR    = 3'b100;
   localparam logic [2:0] ALUOP_SLT   = 3'b101;
   localparam logic [2:0] ALUOP_LUI   = 3'b110;
   localparam logic [2:0] ALUOP_XOR   = 3'b111;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   function automatic logic is_mdu_funct(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
   endfunction

   // MDU and HI/LO moves keep the ALU on a harmless add.
   function automatic logic [3:0] rtype_ctrl(input logic [5:0] f);
      logic [3:0] c;
      case (f)
         F_ADD, F_ADDU:                      c = ALU_ADD;
         F_SUB, F_SUBU:                      c = ALU_SUB;
         F_AND:                              c = ALU_AND;
         F_OR:                               c = ALU_OR;
         F_XOR:                              c = ALU_XOR;
         F_NOR:                              c = ALU_NOR;
         F_SLT:                              c = ALU_SLT;
         F_SLTU:                             c = ALU_SLTU;
         F_SLL:                              c = ALU_SLL;
         F_SRL:                              c = ALU_SRL;
         F_SRA:                              c = ALU_SRA;
         F_MULT, F_MULTU, F_DIV, F_DIVU,
         F_MTHI, F_MTLO:                     c = ALU_ADD;
         default:                            c = ALU_ILL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/aludec_mdu_iter.sv
// Iterative multiply/divide datapath: latches operand magnitudes and result
// signs on start_i, performs one shift-add or restoring-subtract step per
// step_i, and presents the sign-corrected {hi,lo} together with done_o on
// the final step.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       load operands (is_div_i / is_signed_i select the operation)
//   step_i        advance one iteration
//   src_a_i/b_i   operands (dividend/divisor or multiplicand/multiplier)
//   done_o        high on the final iteration; hi_o/lo_o valid that cycle
//   hi_o, lo_o    result (product halves, or remainder/quotient)
module aludec_mdu_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic             is_signed_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   // acc: upper WIDTH+1 bits are partial product / remainder, lower WIDTH
   // bits are the multiplier / dividend shifting into the quotient.
   logic [2*WIDTH:0]   acc_q, acc_d, mul_acc, div_acc;
   logic [WIDTH-1:0]   opd_q, opd_d, a_orig_q, a_orig_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               is_div_q, is_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
   logic               div0_q, div0_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, r_sh;
   logic [WIDTH+1:0]   diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   always_comb begin
      a_neg = is_signed_i & src_a_i[WIDTH-1];
      b_neg = is_signed_i & src_b_i[WIDTH-1];
      a_mag = a_neg ? -src_a_i : src_a_i;
      b_mag = b_neg ? -src_b_i : src_b_i;

      mul_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opd_q} : '0);
      mul_acc = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

      r_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff    = {1'b0, r_sh} - {2'b00, opd_q};
      div_acc = diff[WIDTH+1] ? {r_sh, acc_q[WIDTH-2:0], 1'b0}
                              : {diff[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};

      acc_d    = acc_q;
      opd_d    = opd_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      div0_d   = div0_q;
      a_orig_d = a_orig_q;
      if (start_i) begin
         acc_d    = {{(WIDTH+1){1'b0}}, (is_div_i ? a_mag : b_mag)};
         opd_d    = is_div_i ? b_mag : a_mag;
         cnt_d    = '0;
         is_div_d = is_div_i;
         neg_q_d  = a_neg ^ b_neg;
         neg_r_d  = a_neg;
         div0_d   = is_div_i && (src_b_i == '0);
         a_orig_d = src_a_i;
      end else if (step_i) begin
         acc_d = is_div_q ? div_acc : mul_acc;
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign done_o = step_i && (cnt_q == CNT_W'(WIDTH - 1));

   // Result is formed from the post-step accumulator so it is ready on the
   // same cycle done_o is raised.
   always_comb begin
      prod = acc_d[2*WIDTH-1:0];
      if (neg_q_q) prod = -prod;
      quo = acc_d[WIDTH-1:0];
      rem = acc_d[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         if (div0_q) begin
            lo_o = '1;
            hi_o = a_orig_q;
         end else begin
            lo_o = neg_q_q ? -quo : quo;
            hi_o = neg_r_q ? -rem : rem;
         end
      end else begin
         hi_o = prod[2*WIDTH-1:WIDTH];
         lo_o = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         opd_q    <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         div0_q   <= 1'b0;
         a_orig_q <= '0;
      end else begin
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         div0_q   <= div0_d;
         a_orig_q <= a_orig_d;
      end
   end

endmodule

// File: rtl/aludec_mdu.sv
// EX-stage ALU decoder with an iterative multiply/divide unit and HI/LO.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_i, flush_i    EX instruction valid; EX flush (aborts MDU op)
//   alu_op, funct       decode inputs
//   src_a, src_b        rs / rt operands
//   alu_control         4-bit ALU control, illegal_o for undecoded R-type
//   stall_o             hold IF/ID/EX while an MDU op is in progress
//   hi_o, lo_o          HI/LO registers
//
// state | meaning
// IDLE  | no MDU op; mult/div may start, mthi/mtlo may write
// MUL   | multiply iterations in progress, stalling
// DIV   | divide iterations in progress, stalling
// DONE  | HI/LO just written; one cycle so the held instruction cannot restart
module aludec_mdu
   import aludec_mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic             flush_i,
   input  logic [2:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [3:0]       alu_control,
   output logic             illegal_o,
   output logic             stall_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   mdu_state_e       state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] mdu_hi, mdu_lo;
   logic             is_rtype, idle, busy, start, step, mdu_done;

   always_comb begin
      case (alu_op)
         ALUOP_ADD:   alu_control = ALU_ADD;
         ALUOP_SUB:   alu_control = ALU_SUB;
         ALUOP_RTYPE: alu_control = rtype_ctrl(funct);
         ALUOP_AND:   alu_control = ALU_AND;
         ALUOP_OR:    alu_control = ALU_OR;
         ALUOP_SLT:   alu_control = ALU_SLT;
         ALUOP_LUI:   alu_control = ALU_LUI;
         default:     alu_control = ALU_XOR;
      endcase
   end

   assign is_rtype  = (alu_op == ALUOP_RTYPE);
   assign illegal_o = is_rtype && (alu_control == ALU_ILL);
   assign idle      = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign start     = idle && valid_i && is_rtype && is_mdu_funct(funct) && !flush_i;
   assign step      = busy && !flush_i;
   assign stall_o   = start || step;

   aludec_mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .step_i      (step),
      .is_div_i    (funct[1]),
      .is_signed_i (!funct[0]),
      .src_a_i     (src_a),
      .src_b_i     (src_b),
      .done_o      (mdu_done),
      .hi_o        (mdu_hi),
      .lo_o        (mdu_lo)
   );

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) state_d = funct[1] ? ST_DIV : ST_MUL;
               if (valid_i && is_rtype && funct == F_MTHI) hi_d = src_a;
               if (valid_i && is_rtype && funct == F_MTLO) lo_d = src_a;
            end
            ST_MUL, ST_DIV: begin
               if (mdu_done) begin
                  state_d = ST_DONE;
                  hi_d    = mdu_hi;
                  lo_d    = mdu_lo;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_aludec_mdu.sv
// Bench for aludec_mdu: a cycle model of decode, stall and HI/LO built from
// plain 64-bit arithmetic, checked every cycle, plus literal directed cases.
module tb_aludec_mdu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, valid_i, flush_i;
   logic [2:0]   alu_op;
   logic [5:0]   funct;
   logic [W-1:0] src_a, src_b;
   logic [3:0]   alu_control;
   logic         illegal_o, stall_o;
   logic [W-1:0] hi_o, lo_o;

   always #5 clk = ~clk;

   aludec_mdu #(.WIDTH(W), .CNT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (valid_i),
      .flush_i     (flush_i),
      .alu_op      (alu_op),
      .funct       (funct),
      .src_a       (src_a),
      .src_b       (src_b),
      .alu_control (alu_control),
      .illegal_o   (illegal_o),
      .stall_o     (stall_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   int checks = 0;
   int errors = 0;

   logic [5:0] flist [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h1a,
                              6'h1b, 6'h11};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // {illegal, alu_control} from the decode table
   function automatic logic [4:0] exp_dec(input logic [2:0] op, input logic [5:0] f);
      case (op)
         3'd0: return 5'b0_0010;
         3'd1: return 5'b0_0110;
         3'd3: return 5'b0_0000;
         3'd4: return 5'b0_0001;
         3'd5: return 5'b0_0111;
         3'd6: return 5'b0_1011;
         3'd7: return 5'b0_0011;
         default: begin
            case (f)
               6'h20, 6'h21: return 5'b0_0010;
               6'h22, 6'h23: return 5'b0_0110;
               6'h24: return 5'b0_0000;
               6'h25: return 5'b0_0001;
               6'h26: return 5'b0_0011;
               6'h27: return 5'b0_0100;
               6'h2a: return 5'b0_0111;
               6'h2b: return 5'b0_1000;
               6'h00: return 5'b0_0101;
               6'h02: return 5'b0_1001;
               6'h03: return 5'b0_1010;
               6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13: return 5'b0_0010;
               default: return 5'b1_1111;
            endcase
         end
      endcase
   endfunction

   // {hi, lo} an MDU op must produce
   function automatic logic [63:0] mdu_ref(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         6'h18: p = 64'(sa * sb);
         6'h19: p = {32'd0, a} * {32'd0, b};
         6'h1a: begin
            if (b == 0) p = {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'd0, 32'h80000000};
            else p = {32'(sa % sb), 32'(sa / sb)};
         end
         default: begin
            if (b == 0) p = {a, 32'hFFFFFFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int           m_busy = 0;
   bit           m_done = 0;

   initial begin : model
      bit          idle, start, is_mdu;
      logic [4:0]  d;
      logic [63:0] r;
      forever begin
         @(negedge clk);
         idle   = (m_busy == 0) && !m_done;
         is_mdu = valid_i && alu_op == 3'd2 && (funct inside {6'h18, 6'h19, 6'h1a, 6'h1b});
         start  = idle && is_mdu && !flush_i;
         if (!rst) begin
            d = exp_dec(alu_op, funct);
            check("alu_control", 64'(alu_control), 64'(d[3:0]));
            check("illegal", 64'(illegal_o), 64'(d[4]));
            check("stall", 64'(stall_o), 64'(!flush_i && (start || m_busy > 0)));
            check("hi", 64'(hi_o), 64'(m_hi));
            check("lo", 64'(lo_o), 64'(m_lo));
         end
         if (rst) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0;
         end else if (flush_i) begin
            m_busy = 0; m_done = 0;
         end else if (start) begin
            r = mdu_ref(funct, src_a, src_b);
            p_hi = r[63:32]; p_lo = r[31:0];
            m_busy = W;
         end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1;
            end
         end else if (m_done) begin
            m_done = 0;
         end else if (valid_i && alu_op == 3'd2 && funct == 6'h11) begin
            m_hi = src_a;
         end else if (valid_i && alu_op == 3'd2 && funct == 6'h13) begin
            m_lo = src_a;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue an MDU op, hold it while stalled, then check length and result.
   task automatic run_mdu(input string name, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int n;
      n = 0;
      valid_i = 1'b1; alu_op = 3'd2; funct = f; src_a = a; src_b = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!stall_o) break;
         n++;
         tick();
      end
      check({name, "_stall_len"}, 64'(n), 64'(W + 1));
      check({name, "_hi"}, 64'(hi_o), 64'(ehi));
      check({name, "_lo"}, 64'(lo_o), 64'(elo));
      tick();
      valid_i = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_opd();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'd1;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
      alu_op = '0; funct = '0; src_a = '0; src_b = '0;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_hi", 64'(hi_o), 64'd0);
      check("reset_lo", 64'(lo_o), 64'd0);
      check("reset_stall", 64'(stall_o), 64'd0);
      tick();

      for (int op = 0; op < 8; op++) begin
         alu_op = 3'(op); funct = 6'h20;
         tick();
      end
      alu_op = 3'd2;
      for (int i = 0; i < 18; i++) begin
         funct = flist[i];
         tick();
      end
      funct = 6'h13; tick();
      funct = 6'h3f;
      @(negedge clk);
      check("dec_3f_ctrl", 64'(alu_control), 64'hF);
      check("dec_3f_illegal", 64'(illegal_o), 64'd1);
      tick();
      funct = 6'h2b;
      @(negedge clk);
      check("dec_sltu_ctrl", 64'(alu_control), 64'h8);
      tick();

      run_mdu("mult",  6'h18, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_mdu("multu", 6'h19, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
      run_mdu("div",   6'h1a, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_mdu("divu0", 6'h1b, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
      run_mdu("divmin", 6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

      // flush at iteration 10 of a mult
      valid_i = 1'b1; alu_op = 3'd2; funct = 6'h18; src_a = 32'd5; src_b = 32'd7;
      repeat (10) tick();
      flush_i = 1'b1;
      @(negedge clk);
      check("flush_stall", 64'(stall_o), 64'd0);
      tick();
      flush_i = 1'b0; valid_i = 1'b0;
      @(negedge clk);
      check("flush_stall_next", 64'(stall_o), 64'd0);
      check("flush_hi", 64'(hi_o), 64'd0);
      check("flush_lo", 64'(lo_o), 64'h80000000);
      tick();

      // reset in the middle of a divide
      valid_i = 1'b1; alu_op = 3'd2; funct = 6'h1a; src_a = 32'd100; src_b = 32'd7;
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_hi", 64'(hi_o), 64'd0);
      check("rst_lo", 64'(lo_o), 64'd0);
      run_mdu("div_after_rst", 6'h1a, 32'd100, 32'd7, 32'd2, 32'd14);

      // back-to-back mthi / mtlo
      valid_i = 1'b1; alu_op = 3'd2; funct = 6'h11; src_a = 32'h12345678;
      @(negedge clk);
      check("mthi_stall", 64'(stall_o), 64'd0);
      tick();
      funct = 6'h13; src_a = 32'h9ABCDEF0;
      @(negedge clk);
      check("mtlo_stall", 64'(stall_o), 64'd0);
      check("mthi_hi", 64'(hi_o), 64'h12345678);
      tick();
      valid_i = 1'b0;
      @(negedge clk);
      check("mtlo_lo", 64'(lo_o), 64'h9ABCDEF0);
      check("mtlo_hi_kept", 64'(hi_o), 64'h12345678);
      tick();

      for (int n = 0; n < 4000; n++) begin
         if (m_busy == 0) begin
            valid_i = ($urandom_range(0, 3) != 0);
            alu_op  = ($urandom_range(0, 1) != 0) ? 3'd2 : 3'($urandom_range(0, 7));
            funct   = ($urandom_range(0, 3) != 0) ? flist[$urandom_range(0, 17)] : 6'($urandom);
            src_a   = rnd_opd();
            src_b   = rnd_opd();
         end
         flush_i = ($urandom_range(0, 199) == 0);
         rst     = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
